// File: rtl/standard_switcher_if.sv
// Standard-switcher signal bundle: raw switch input plus registered control outputs.
interface standard_switcher_if #(
  parameter int SEL_W = 1
);
  logic [SEL_W-1:0] standard_sw;
  logic [SEL_W-1:0] std_sel;
  logic             clk_gate;
  logic             cpu_reset;
  logic             busy;
  logic             switch_done;

  modport master (
    output standard_sw,
    input  std_sel, clk_gate, cpu_reset, busy, switch_done
  );

  modport slave (
    input  standard_sw,
    output std_sel, clk_gate, cpu_reset, busy, switch_done
  );
endinterface

// File: rtl/standard_switcher.sv
// Glitch-free video standard switcher: debounces the switch, gates the clock
// around the mux select change, then holds the CPU in reset.
module standard_switcher #(
  parameter int NUM_STD         = 2,
  parameter int SEL_W           = 1,
  parameter int DEFAULT_STD     = 0,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int SETTLE_CYCLES   = 64,
  parameter int RESET_CYCLES    = 1024
) (
  input  logic                clk_dot4x,
  input  logic                rst,
  standard_switcher_if.slave  sw_if
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > RESET_CYCLES) ? MAX_AB : RESET_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_STD_W   = (SEL_W + 1)'(NUM_STD);
  localparam logic [SEL_W-1:0] DEF_SEL     = SEL_W'(DEFAULT_STD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_GATE,
    ST_SWAP,
    ST_UNGATE,
    ST_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] cand_q, cand_d;
  logic [SEL_W-1:0] std_sel_q, std_sel_d;
  logic [SEL_W-1:0] sync1_q, sync2_q;
  logic             clk_gate_q, clk_gate_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             busy_q, busy_d;
  logic             switch_done_q, switch_done_d;
  logic [SEL_W-1:0] sw_sync;

  assign sw_sync = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    std_sel_d = std_sel_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if ((sw_sync != std_sel_q) && ({1'b0, sw_sync} < NUM_STD_W)) begin
          cand_d  = sw_sync;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (sw_sync != cand_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_GATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GATE: begin
        // Select is loaded on the GATE->SWAP edge so it is visible for the SWAP cycle.
        if (cnt_q == SETTLE_LAST) begin
          state_d   = ST_SWAP;
          std_sel_d = cand_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SWAP: begin
        state_d = ST_UNGATE;
        cnt_d   = '0;
      end
      ST_UNGATE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == RESET_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so every output is a flop.
    clk_gate_d    = (state_d == ST_GATE) || (state_d == ST_SWAP) || (state_d == ST_UNGATE);
    cpu_reset_d   = (state_d == ST_HOLD);
    busy_d        = (state_d != ST_IDLE);
    switch_done_d = (state_q == ST_HOLD) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      cand_q        <= DEF_SEL;
      std_sel_q     <= DEF_SEL;
      sync1_q       <= DEF_SEL;
      sync2_q       <= DEF_SEL;
      clk_gate_q    <= 1'b0;
      cpu_reset_q   <= 1'b1;
      busy_q        <= 1'b1;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      std_sel_q     <= std_sel_d;
      sync1_q       <= sw_if.standard_sw;
      sync2_q       <= sync1_q;
      clk_gate_q    <= clk_gate_d;
      cpu_reset_q   <= cpu_reset_d;
      busy_q        <= busy_d;
      switch_done_q <= switch_done_d;
    end
  end

  assign sw_if.std_sel     = std_sel_q;
  assign sw_if.clk_gate    = clk_gate_q;
  assign sw_if.cpu_reset   = cpu_reset_q;
  assign sw_if.busy        = busy_q;
  assign sw_if.switch_done = switch_done_q;

endmodule

// File: tb/tb_standard_switcher.sv
// Bench for standard_switcher: two instances (4 and 3 standards) share one switch input,
// checked against a timeline model keyed on elapsed cycles since a request.
module tb_standard_switcher;
  localparam int D = 8;
  localparam int S = 4;
  localparam int R = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sw  = 2'd0;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  standard_switcher_if #(.SEL_W(2)) if4 ();
  standard_switcher_if #(.SEL_W(2)) if3 ();
  assign if4.standard_sw = sw;
  assign if3.standard_sw = sw;

  standard_switcher #(
    .NUM_STD(4), .SEL_W(2), .DEFAULT_STD(0),
    .DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S), .RESET_CYCLES(R)
  ) dut4 (.clk_dot4x(clk), .rst(rst), .sw_if(if4));

  standard_switcher #(
    .NUM_STD(3), .SEL_W(2), .DEFAULT_STD(0),
    .DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S), .RESET_CYCLES(R)
  ) dut3 (.clk_dot4x(clk), .rst(rst), .sw_if(if3));

  logic [5:0] obs [2];
  assign obs[0] = {if4.std_sel, if4.clk_gate, if4.cpu_reset, if4.busy, if4.switch_done};
  assign obs[1] = {if3.std_sel, if3.clk_gate, if3.cpu_reset, if3.busy, if3.switch_done};

  // Model: a request starts at elapsed e=0; everything else is a window of e.
  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] sel;
    logic [1:0] cand;
    bit         active;
    int         e;
    bit         done;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t mdl_reset();
    mdl_t x;
    x        = '0;
    x.active = 1'b1;
    x.e      = D + 2*S + 1;
    return x;
  endfunction

  function automatic mdl_t step(mdl_t c, logic [1:0] swv, int nstd);
    mdl_t n;
    n      = c;
    n.done = 1'b0;
    if (!c.active) begin
      if (c.s2 != c.sel && int'(c.s2) < nstd) begin
        n.active = 1'b1;
        n.e      = 0;
        n.cand   = c.s2;
      end
    end else begin
      n.e = c.e + 1;
      if (n.e <= D && c.s2 != c.cand) n.active = 1'b0;
      else begin
        if (n.e == D + S) n.sel = c.cand;
        if (n.e == D + 2*S + R + 1) begin
          n.active = 1'b0;
          n.done   = 1'b1;
        end
      end
    end
    n.s2 = c.s1;
    n.s1 = swv;
    return n;
  endfunction

  function automatic logic [5:0] exp_vec(mdl_t x);
    logic g, c;
    g = x.active && x.e >= D && x.e <= D + 2*S;
    c = x.active && x.e > D + 2*S && x.e <= D + 2*S + R;
    return {x.sel, g, c, x.active, x.done};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 2; i++) m[i] <= mdl_reset();
    else     for (int i = 0; i < 2; i++) m[i] <= step(m[i], sw, (i == 0) ? 4 : 3);
  end

  task automatic test_reset();
    int cpu_n = 0, done_n = 0;
    rst = 1'b1; sw = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 6'b000110) begin bad++; $display("FAIL reset_state dut%0d got=%b want=000110", i, obs[i]); end
    end
    rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL reset_seq dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
      end
      if (if4.cpu_reset) cpu_n++;
      if (if4.switch_done) done_n++;
    end
    total++; if (cpu_n != R) begin bad++; $display("FAIL reset_hold_len got=%0d want=%0d", cpu_n, R); end
    total++; if (done_n != 1) begin bad++; $display("FAIL reset_done_pulses got=%0d want=1", done_n); end
    total++; if (if4.busy !== 1'b0 || if4.std_sel !== 2'd0) begin bad++; $display("FAIL reset_idle got busy=%b sel=%0d want busy=0 sel=0", if4.busy, if4.std_sel); end
  endtask

  task automatic test_glitch();
    int gate_n = 0, busy_n = 0;
    @(posedge clk); #1 sw = 2'd2;
    for (int c = 0; c < 35; c++) begin
      if (c == 5) sw = 2'd0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL glitch dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
      end
      if (if4.clk_gate) gate_n++;
      if (if4.busy) busy_n++;
    end
    total++; if (gate_n != 0) begin bad++; $display("FAIL glitch_gate got=%0d want=0", gate_n); end
    total++; if (busy_n == 0) begin bad++; $display("FAIL glitch_debounce_entered got=0 want>0"); end
    total++; if (if4.std_sel !== 2'd0) begin bad++; $display("FAIL glitch_sel got=%0d want=0", if4.std_sel); end
  endtask

  task automatic test_switch();
    int gate_n = 0, cpu_n = 0, done_n = 0, sel_idx = 0;
    @(posedge clk); #1 sw = 2'd2;
    repeat (60) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL switch dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
      end
      if (if4.clk_gate) begin
        gate_n++;
        if (if4.std_sel === 2'd2 && sel_idx == 0) sel_idx = gate_n;
      end
      if (if4.cpu_reset) cpu_n++;
      if (if4.switch_done) done_n++;
    end
    total++; if (gate_n != 2*S + 1) begin bad++; $display("FAIL switch_gate_len got=%0d want=%0d", gate_n, 2*S + 1); end
    total++; if (sel_idx != S + 1) begin bad++; $display("FAIL switch_sel_mid got=%0d want=%0d", sel_idx, S + 1); end
    total++; if (cpu_n != R) begin bad++; $display("FAIL switch_hold_len got=%0d want=%0d", cpu_n, R); end
    total++; if (done_n != 1) begin bad++; $display("FAIL switch_done got=%0d want=1", done_n); end
  endtask

  task automatic test_back_to_back();
    int w = 0, d0 = 0, d1 = 0;
    logic [1:0] sel_at [2];
    sel_at[0] = 2'd0; sel_at[1] = 2'd0;
    @(posedge clk); #1 sw = 2'd3;
    while (if4.clk_gate !== 1'b1 && w < 50) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL b2b_wait dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
      end
      w++;
    end
    total++; if (if4.clk_gate !== 1'b1) begin bad++; $display("FAIL b2b_gate_timeout got=%b want=1", if4.clk_gate); end
    @(posedge clk); #1 sw = 2'd1;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL b2b dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
      end
      if (if4.switch_done) begin
        if (d0 < 2) sel_at[d0] = if4.std_sel;
        d0++;
      end
      if (if3.switch_done) d1++;
    end
    total++; if (d0 != 2) begin bad++; $display("FAIL b2b_n4_done got=%0d want=2", d0); end
    total++; if (sel_at[0] !== 2'd3) begin bad++; $display("FAIL b2b_first_sel got=%0d want=3", sel_at[0]); end
    total++; if (sel_at[1] !== 2'd1) begin bad++; $display("FAIL b2b_second_sel got=%0d want=1", sel_at[1]); end
    total++; if (d1 != 1 || if3.std_sel !== 2'd1) begin bad++; $display("FAIL b2b_n3 got done=%0d sel=%0d want done=1 sel=1", d1, if3.std_sel); end
  endtask

  task automatic test_out_of_range();
    int busy3 = 0;
    @(posedge clk); #1 sw = 2'd3;
    repeat (45) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL oor dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
      end
      if (if3.busy) busy3++;
    end
    total++; if (busy3 != 0) begin bad++; $display("FAIL oor_n3_busy got=%0d want=0", busy3); end
    total++; if (if3.std_sel !== 2'd1) begin bad++; $display("FAIL oor_n3_sel got=%0d want=1", if3.std_sel); end
    total++; if (if4.std_sel !== 2'd3) begin bad++; $display("FAIL oor_n4_sel got=%0d want=3", if4.std_sel); end
  endtask

  task automatic test_reset_mid();
    int w = 0, cpu_n = 0, done_n = 0;
    @(posedge clk); #1 sw = 2'd2;
    while (!(if4.clk_gate === 1'b1 && if4.std_sel === 2'd2) && w < 60) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL rmid_wait dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
      end
      w++;
    end
    total++; if (if4.std_sel !== 2'd2) begin bad++; $display("FAIL rmid_swap_timeout got=%0d want=2", if4.std_sel); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 6'b000110) begin bad++; $display("FAIL rmid_async dut%0d got=%b want=000110", i, obs[i]); end
    end
    sw = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL rmid_seq dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
      end
      if (if4.cpu_reset) cpu_n++;
      if (if4.switch_done) done_n++;
    end
    total++; if (cpu_n != R) begin bad++; $display("FAIL rmid_hold_len got=%0d want=%0d", cpu_n, R); end
    total++; if (done_n != 1) begin bad++; $display("FAIL rmid_done got=%0d want=1", done_n); end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 120; seg++) begin
      int hold;
      @(posedge clk); #1;
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
      sw   = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 45);
      repeat (hold) begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          total++;
          if (obs[i] !== exp_vec(m[i])) begin bad++; $display("FAIL random dut%0d t=%0t got=%b want=%b", i, $time, obs[i], exp_vec(m[i])); end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glitch();
    test_switch();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/standard_switcher.md
STANDARD_SWITCHER -- requirements
Module: standard_switcher

Interface
REQ-001 SHALL have parameter NUM_STD, default 2, number of selectable video standards / chip models.
REQ-002 SHALL have parameter SEL_W, default 1, width of the standard select, with NUM_STD <= 2**SEL_W.
REQ-003 SHALL have parameter DEFAULT_STD, default 0, standard loaded on reset.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 65536, stable-input time required before a switch.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 64, clock-gate guard time on each side of the select change.
REQ-006 SHALL have parameter RESET_CYCLES, default 1024, CPU reset hold time after a switch or reset.
REQ-007 SHALL have port clk_dot4x  input  1  sole clock.
REQ-008 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port standard_sw  input  SEL_W  raw switch/config value, asynchronous to clk_dot4x.
REQ-010 SHALL have port std_sel  output  SEL_W  registered active standard, driving the clock-mux select and chip id.
REQ-011 SHALL have port clk_gate  output  1  high = clock buffer CE must be deasserted.
REQ-012 SHALL have port cpu_reset  output  1  high = hold CPU/vicii in reset.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-014 SHALL have port switch_done  output  1  one-cycle strobe at HOLD->IDLE.

Function
REQ-015 SHALL pass standard_sw through a 2-flop synchroniser; sw_sync denotes its output, and all decisions SHALL use sw_sync only.
REQ-016 SHALL implement FSM states IDLE, DEBOUNCE, GATE, SWAP, UNGATE, HOLD.
REQ-017 SHALL, in IDLE, latch cand<=sw_sync, clear the counter, and go to DEBOUNCE when sw_sync != std_sel and sw_sync < NUM_STD; otherwise it SHALL stay in IDLE.
REQ-018 SHALL treat sw_sync >= NUM_STD as no request, never loading it into std_sel.
REQ-019 SHALL, in DEBOUNCE, return to IDLE with no output change if sw_sync != cand; otherwise it SHALL increment the counter and go to GATE after DEBOUNCE_CYCLES consecutive matching cycles.
REQ-020 SHALL, in GATE, drive clk_gate=1 for SETTLE_CYCLES cycles, then go to SWAP.
REQ-021 SHALL, in SWAP, load std_sel<=cand for exactly one cycle with clk_gate=1, then go to UNGATE.
REQ-022 SHALL, in UNGATE, hold clk_gate=1 for SETTLE_CYCLES cycles, then go to HOLD.
REQ-023 SHALL, as a result, keep clk_gate high for exactly 2*SETTLE_CYCLES+1 consecutive cycles, with std_sel changing only mid-window.
REQ-024 SHALL, in HOLD, drive cpu_reset=1 and clk_gate=0 for RESET_CYCLES cycles, then enter IDLE and pulse switch_done.
REQ-025 SHALL ignore sw_sync changes in GATE/SWAP/UNGATE/HOLD; the IDLE entry SHALL re-evaluate sw_sync, so a second change starts a new sequence.
REQ-026 SHALL, in IDLE, start a new sequence if sw_sync equals the pre-switch value after a completed switch (no suppression).
REQ-027 SHALL size a single shared counter as $clog2 of the largest of DEBOUNCE_CYCLES, SETTLE_CYCLES and RESET_CYCLES, plus 1, with no wrap during any count.
REQ-028 SHALL register all outputs, with no combinational path from standard_sw to any output.

Reset
REQ-029 SHALL, on rst=1 (asynchronous), force std_sel=DEFAULT_STD, clk_gate=0, cpu_reset=1, busy=1, switch_done=0, synchroniser=DEFAULT_STD, counter=0, and state=HOLD.
REQ-030 SHALL, after rst falls, complete HOLD (RESET_CYCLES cycles with cpu_reset=1), then reach IDLE with a switch_done pulse.
REQ-031 SHALL, when rst is asserted mid-sequence (any state), abort, restore std_sel=DEFAULT_STD, and drop clk_gate within the same asynchronous event.

Verification
REQ-032 SHALL cover this directed scenario (NUM_STD=4, SEL_W=2, DEBOUNCE=8, SETTLE=4, RESET=16 for all): release rst with standard_sw=0 -> cpu_reset high 16 cycles, then busy=0, one switch_done pulse, std_sel=0.
REQ-033 SHALL cover: standard_sw 0->2 held stable -> after 2 sync + 8 debounce cycles clk_gate high for 9 cycles, std_sel=2 on the 5th, then cpu_reset high 16 cycles, then switch_done.
REQ-034 SHALL cover: standard_sw 0->2 for 5 cycles then back to 0 -> return to IDLE, clk_gate never rises, std_sel stays 0.
REQ-035 SHALL cover: standard_sw=3 followed by standard_sw=1 during GATE -> std_sel=3 after the first sequence, then a second full sequence ends with std_sel=1.
REQ-036 SHALL cover: with NUM_STD=3, standard_sw=3 -> FSM remains IDLE and std_sel is unchanged.
REQ-037 SHALL cover: rst pulse during UNGATE -> immediately std_sel=DEFAULT_STD, clk_gate=0, cpu_reset=1, and the post-reset HOLD sequence repeats.
